// File: rtl/stim_stream_fifo.sv
// stim_stream_fifo
//   Valid/ready FWFT buffer placed between the stimulus driver and the DUT
//   input port. Provides occupancy count, almost-full watermark and a
//   synchronous flush. All flags are registered.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   flush        synchronous clear (overrides push/pop in the same cycle)
//   s_valid      upstream word valid
//   s_ready      FIFO can accept (registered !full)
//   s_data       upstream word
//   m_valid      head word available (registered !empty)
//   m_ready      downstream consumes head
//   m_data       head word, zero when empty
//   level        occupancy 0..DEPTH
//   almost_full  level >= AFULL (registered)
module stim_stream_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int AFULL = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [WIDTH-1:0]           s_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [WIDTH-1:0]           m_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       almost_full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] AFULL_L = (AW+1)'(AFULL);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;
  logic [AW:0]      r_level;
  logic             r_sready;
  logic             r_mvalid;
  logic             r_afull;
  logic [WIDTH-1:0] r_head;

  logic             w_push;
  logic             w_pop;
  logic [AW:0]      w_wr_nxt;
  logic [AW:0]      w_rd_nxt;
  logic [AW:0]      w_lvl_nxt;
  logic             w_empty_nxt;
  logic             w_full_nxt;
  logic [WIDTH-1:0] w_head_nxt;

  always_comb begin
    w_push      = s_valid && r_sready && !flush;
    w_pop       = r_mvalid && m_ready && !flush;
    w_wr_nxt    = flush ? '0 : r_wr + (AW+1)'(w_push);
    w_rd_nxt    = flush ? '0 : r_rd + (AW+1)'(w_pop);
    w_lvl_nxt   = w_wr_nxt - w_rd_nxt;
    w_empty_nxt = (w_wr_nxt == w_rd_nxt);
    w_full_nxt  = (w_wr_nxt[AW] != w_rd_nxt[AW]) &&
                  (w_wr_nxt[AW-1:0] == w_rd_nxt[AW-1:0]);
    // Head is registered; when the next head slot is the one being written
    // this cycle (FIFO drains to exactly the new word) take it from s_data.
    if (w_empty_nxt)
      w_head_nxt = '0;
    else if (w_push && (w_rd_nxt[AW-1:0] == r_wr[AW-1:0]))
      w_head_nxt = s_data;
    else
      w_head_nxt = r_mem[w_rd_nxt[AW-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr     <= '0;
      r_rd     <= '0;
      r_level  <= '0;
      r_sready <= 1'b1;
      r_mvalid <= 1'b0;
      r_afull  <= 1'b0;
      r_head   <= '0;
    end else begin
      r_wr     <= w_wr_nxt;
      r_rd     <= w_rd_nxt;
      r_level  <= w_lvl_nxt;
      r_sready <= !w_full_nxt;
      r_mvalid <= !w_empty_nxt;
      r_afull  <= (w_lvl_nxt >= AFULL_L);
      r_head   <= w_head_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr[AW-1:0]] <= s_data;
  end

  assign s_ready     = r_sready;
  assign m_valid     = r_mvalid;
  assign m_data      = r_head;
  assign level       = r_level;
  assign almost_full = r_afull;

endmodule

// File: tb/tb_stim_stream_fifo.sv
module tb_stim_stream_fifo;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic [4:0]  level;
  logic        almost_full;

  int total = 0;
  int bad   = 0;

  stim_stream_fifo #(.WIDTH(32), .DEPTH(16), .AFULL(12)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .level(level), .almost_full(almost_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, ".level"},   32'(level),       32'd0);
    chk({tag, ".m_valid"}, 32'(m_valid),     32'd0);
    chk({tag, ".s_ready"}, 32'(s_ready),     32'd1);
    chk({tag, ".afull"},   32'(almost_full), 32'd0);
    chk({tag, ".m_data"},  m_data,           32'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    #12;
    chk_empty("reset");
    rst = 1'b0;
    step();

    // fill 0x00..0x0F with m_ready low, watching the watermark
    for (int i = 0; i < 16; i++) begin
      s_valid = 1'b1;
      s_data  = 32'(i);
      step();
      chk("fill.level", 32'(level), 32'(i + 1));
      if (i == 10) chk("afull.at11", 32'(almost_full), 32'd0);
      if (i == 11) chk("afull.at12", 32'(almost_full), 32'd1);
    end
    chk("full.s_ready", 32'(s_ready), 32'd0);
    chk("full.m_data",  m_data,       32'h00);

    // full with simultaneous push attempt and pop: only the pop happens
    s_data  = 32'h10;
    m_ready = 1'b1;
    step();
    chk("fullpop.level",   32'(level),   32'd15);
    chk("fullpop.s_ready", 32'(s_ready), 32'd1);
    chk("fullpop.m_data",  m_data,       32'h01);
    m_ready = 1'b0;
    step();
    chk("held.level",   32'(level),   32'd16);
    chk("held.s_ready", 32'(s_ready), 32'd0);
    s_valid = 1'b0;

    // drain: expect 0x01..0x10 in order, watermark drops at 12 -> 11
    m_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      chk("drain.m_valid", 32'(m_valid), 32'd1);
      chk("drain.m_data",  m_data,       32'(i));
      step();
      chk("drain.level", 32'(level),       32'(16 - i));
      chk("drain.afull", 32'(almost_full), (16 - i >= 12) ? 32'd1 : 32'd0);
    end
    m_ready = 1'b0;
    chk_empty("drained");

    // streaming 0..99 with push and pop every cycle
    s_valid = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      s_data = 32'(i);
      step();
      chk("stream.level",  32'(level), 32'd1);
      chk("stream.m_data", m_data,     32'(i));
    end
    s_valid = 1'b0;
    step();
    m_ready = 1'b0;
    chk_empty("stream.end");

    // flush at level 7 with concurrent push and pop
    for (int i = 0; i < 7; i++) begin
      s_valid = 1'b1;
      s_data  = 32'h70 + 32'(i);
      step();
    end
    chk("preflush.level", 32'(level), 32'd7);
    flush = 1'b1; s_data = 32'hEE; m_ready = 1'b1;
    step();
    flush = 1'b0; m_ready = 1'b0;
    chk_empty("flush");
    s_data = 32'hA5;
    step();
    s_valid = 1'b0;
    chk("postflush.level",  32'(level), 32'd1);
    chk("postflush.m_data", m_data,     32'hA5);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    chk_empty("postflush.pop");

    // asynchronous reset mid-burst at level 5
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_data  = 32'h50 + 32'(i);
      step();
    end
    chk("prerst.level", 32'(level), 32'd5);
    #3;
    rst = 1'b1;
    #1;
    chk_empty("asyncrst");
    s_data = 32'h3C;
    @(negedge clk);
    rst = 1'b0;
    step();
    s_valid = 1'b0;
    chk("postrst.level",  32'(level), 32'd1);
    chk("postrst.m_data", m_data,     32'h3C);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    chk_empty("postrst.pop");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
